sdram_page_negotiator: RTL
==========================

Name: sdram_page_negotiator

Overview:
- Parametrised successor to the single-pointer page negotiator between the pipe FIFOs and `sdramctrl`.
- Decides when to issue page writes (in-FIFO to SDRAM) and page reads (SDRAM to out-FIFO), based on FIFO fill levels.
- Keeps independent write and read row pointers with a runtime wrap limit.
- Arbitrates fairly when both directions are eligible, and flags a stuck controller with a watchdog.
- Sits in the `clk` domain. FIFOs stay outside; only their `clk`-domain level counts come in.

Parameters:
- ADDR_W, 15: row address width, matching `sdramctrl` `rowaddr_in`.
- LVL_W, 11: FIFO level-count width.
- FIFO_DEPTH, 2048: out-FIFO capacity in words.
- PAGE_WORDS, 512: words per page transfer; must be ≤ FIFO_DEPTH.
- TIMEOUT_CYC, 4096: watchdog limit in `clk` cycles per command; must be > 0.

Ports:
- clk, in, 1: system/SDRAM clock.
- reset, in, 1: synchronous, active-high.
- en_write, in, 1: allow SDRAM page writes.
- en_read, in, 1: allow SDRAM page reads.
- in_level, in, LVL_W: in-FIFO read-side word count.
- out_level, in, LVL_W: out-FIFO write-side word count.
- row_limit, in, ADDR_W: number of rows used; the pointer wraps to 0 after row_limit-1. A value of 0 means the full 2^ADDR_W range.
- ptr_clear, in, 1: one-cycle pulse that zeroes both row pointers.
- cmd_pagewrite, out, 1: page-write request to the controller.
- cmd_pageread, out, 1: page-read request to the controller.
- cmd_ack, in, 1: controller accepted the command.
- cmd_done, in, 1: controller finished the page.
- rowaddr, out, ADDR_W: row for the current command.
- busy, out, 1: state is not IDLE.
- wr_row, out, ADDR_W: current write pointer.
- rd_row, out, ADDR_W: current read pointer.
- fault_timeout, out, 1: sticky watchdog fault.
- pages_written, out, 32: optional statistics counter.
- pages_read, out, 32: optional statistics counter.

Behaviour:
- Reset values: all outputs are 0; state is IDLE; the `last_was_write` flag is 0; `clear_pending` is 0.
- Reset is honoured mid-command: requests drop on the next edge, and the controller is expected to be reset by the same signal.
- Eligibility:
  - Write-eligible = en_write and (in_level ≥ PAGE_WORDS).
  - Read-eligible = en_read and (out_level ≤ FIFO_DEPTH − PAGE_WORDS).
  - Compare at LVL_W+1 bits so there is no truncation.
- State IDLE:
  - If only one direction is eligible, go to WACK (write) or RACK (read).
  - If both are eligible, grant the direction opposite to `last_was_write`. Write therefore wins the first tie after reset.
  - If neither is eligible, stay in IDLE.
- State WACK:
  - cmd_pagewrite=1 and rowaddr=wr_row, registered. Both are first visible the cycle after the grant.
  - When cmd_ack is sampled 1: increment wr_row modulo the wrap, set `last_was_write`=1, and go to BUSY.
  - cmd_pagewrite is 0 from the cycle after the ack.
- State RACK: same as WACK using cmd_pageread and rd_row; sets `last_was_write`=0.
- State BUSY:
  - Requests are 0; rowaddr holds its value.
  - cmd_done=1 returns to IDLE; the earliest next grant is evaluated on the following cycle.
  - cmd_done is ignored outside BUSY. cmd_ack is ignored outside WACK/RACK.
- Wrap rule:
  - next = (ptr == row_limit−1) ? 0 : ptr+1.
  - If row_limit = 0, the pointer wraps naturally at 2^ADDR_W.
  - If ptr ≥ row_limit (row_limit was lowered at runtime), next = 0.
- Watchdog:
  - The counter clears on entering WACK or RACK and counts through ACK and BUSY.
  - On reaching TIMEOUT_CYC: set fault_timeout, drop requests, go to IDLE, and leave the pointer unchanged if no ack was received.
  - fault_timeout clears only on reset.
- ptr_clear:
  - In IDLE (and not granting this cycle), zero both pointers on the next edge.
  - Otherwise set `clear_pending`; it is applied on the cycle the FSM re-enters IDLE, and no grant is issued that cycle.
  - If ptr_clear coincides with an ack increment, the clear wins.

Optional Feature:
- Macro SDRAM_NEG_STATS_EN.
- Defined: pages_written and pages_read increment on each accepted ack (write and read respectively), wrap at 2^32, and clear on reset or ptr_clear.
- Undefined: both ports are tied to 0 and the counters are not synthesised.

Decomposition:
- Package `sdram_neg_pkg` holds:
  - the state encoding constants (IDLE=0, WACK=1, RACK=2, BUSY=3);
  - the default PAGE_WORDS, FIFO_DEPTH and TIMEOUT_CYC localparams.
- One natural sub-module, `row_ptr_wrap`: ADDR_W counter with increment, clear, and a row_limit wrap input. It is instantiated twice, once for write and once for read.

Test Plan:
- Write only: reset; en_write=1, in_level=512, ack 3 cycles later, done after 20 cycles → exactly one cmd_pagewrite burst with rowaddr=0; wr_row=1; busy low after done.
- Tie fairness: en_write=en_read=1, in_level=1024, out_level=0, four commands → grant order W,R,W,R; wr_row=2, rd_row=2.
- Wrap: row_limit=3 with 4 write pages → rowaddr sequence 0,1,2,0.
- Watchdog: TIMEOUT_CYC=16, cmd_ack never asserted → fault_timeout=1 at cycle 16 after the request, request drops, wr_row stays 0. Reset clears the fault.
- Threshold boundaries (en_read=1): out_level=1536 → read issued; out_level=1537 → no read. Likewise in_level=511 → no write.
- ptr_clear during BUSY, with SDRAM_NEG_STATS_EN defined: pointers and counters read 0 the cycle after done; no grant is issued that cycle.

Source files
------------

// File: rtl/sdram_neg_pkg.sv
// sdram_neg_pkg: state encoding and default sizing for the sdram page negotiator
package sdram_neg_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WACK = 2'd1,
    RACK = 2'd2,
    BUSY = 2'd3
  } neg_state_t;
  localparam int DEF_PAGE_WORDS = 512;
  localparam int DEF_FIFO_DEPTH = 2048;
  localparam int DEF_TIMEOUT_CYC = 4096;
endpackage

// File: rtl/sdram_page_negotiator_row_ptr.sv
// row_ptr_wrap: row pointer with increment, clear and runtime wrap limit (0 = full range)
module row_ptr_wrap #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  input  logic [ADDR_W-1:0] row_limit,
  output logic [ADDR_W-1:0] ptr
);
  logic [ADDR_W-1:0] last;
  assign last = row_limit - 1'b1;
  always_ff @(posedge clk)
    if (reset || clr) ptr <= '0;
    else if (inc) ptr <= (ptr >= last) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/sdram_page_negotiator.sv
// sdram_page_negotiator: fair page write/read arbiter with watchdog; stats counters under SDRAM_NEG_STATS_EN
module sdram_page_negotiator
  import sdram_neg_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int LVL_W       = 11,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PAGE_WORDS  = DEF_PAGE_WORDS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_write,
  input  logic              en_read,
  input  logic [LVL_W-1:0]  in_level,
  input  logic [LVL_W-1:0]  out_level,
  input  logic [ADDR_W-1:0] row_limit,
  input  logic              ptr_clear,
  output logic              cmd_pagewrite,
  output logic              cmd_pageread,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic [ADDR_W-1:0] rowaddr,
  output logic              busy,
  output logic [ADDR_W-1:0] wr_row,
  output logic [ADDR_W-1:0] rd_row,
  output logic              fault_timeout,
  output logic [31:0]       pages_written,
  output logic [31:0]       pages_read
);
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  neg_state_t state, state_n;
  logic [WD_W-1:0] wd;
  logic wr_elig, rd_elig, grant_w, grant_r, grant, timeout, wr_inc, rd_inc;
  logic reenter, clr_now, last_was_write, clear_pending;
  assign wr_elig = en_write && ({1'b0, in_level} >= (LVL_W+1)'(PAGE_WORDS));
  assign rd_elig = en_read && ({1'b0, out_level} <= (LVL_W+1)'(FIFO_DEPTH - PAGE_WORDS));
  assign timeout = (state != IDLE) && (wd == WD_W'(TIMEOUT_CYC - 1));
  assign grant = grant_w || grant_r;
  assign reenter = (state != IDLE) && (state_n == IDLE);
  assign clr_now = (state == IDLE) ? (clear_pending || (ptr_clear && !grant))
                                   : (reenter && (clear_pending || ptr_clear));
  assign busy = state != IDLE;
  assign cmd_pagewrite = state == WACK;
  assign cmd_pageread = state == RACK;
  always_comb begin
    state_n = state;
    grant_w = 1'b0;
    grant_r = 1'b0;
    wr_inc = 1'b0;
    rd_inc = 1'b0;
    case (state)
      IDLE: begin
        grant_w = !clear_pending && wr_elig && (!rd_elig || !last_was_write);
        grant_r = !clear_pending && rd_elig && !grant_w;
        state_n = grant_w ? WACK : grant_r ? RACK : IDLE;
      end
      WACK: begin
        wr_inc = cmd_ack;
        state_n = timeout ? IDLE : cmd_ack ? BUSY : WACK;
      end
      RACK: begin
        rd_inc = cmd_ack;
        state_n = timeout ? IDLE : cmd_ack ? BUSY : RACK;
      end
      default: state_n = (timeout || cmd_done) ? IDLE : BUSY;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      rowaddr <= '0;
      last_was_write <= 1'b0;
      clear_pending <= 1'b0;
      fault_timeout <= 1'b0;
    end else begin
      state <= state_n;
      wd <= grant ? '0 : (state != IDLE) ? wd + 1'b1 : wd;
      rowaddr <= grant_w ? wr_row : grant_r ? rd_row : rowaddr;
      last_was_write <= wr_inc ? 1'b1 : rd_inc ? 1'b0 : last_was_write;
      clear_pending <= (state == IDLE) ? (ptr_clear && grant) : (clear_pending || ptr_clear);
      fault_timeout <= fault_timeout || timeout;
    end
  row_ptr_wrap #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk(clk), .reset(reset), .inc(wr_inc), .clr(clr_now), .row_limit(row_limit), .ptr(wr_row)
  );
  row_ptr_wrap #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk(clk), .reset(reset), .inc(rd_inc), .clr(clr_now), .row_limit(row_limit), .ptr(rd_row)
  );
`ifdef SDRAM_NEG_STATS_EN
  always_ff @(posedge clk)
    if (reset || clr_now) begin
      pages_written <= '0;
      pages_read <= '0;
    end else begin
      pages_written <= pages_written + {31'd0, wr_inc};
      pages_read <= pages_read + {31'd0, rd_inc};
    end
`else
  assign pages_written = '0;
  assign pages_read = '0;
`endif
endmodule
